// File: rtl/pm_pkg.sv
// Shared types and defaults for the program-memory responder.
package pm_pkg;
  localparam int unsigned PM_DATA_W = 32;
  localparam int unsigned PM_ADDR_W = 16;
  localparam int unsigned PM_DEPTH  = 256;
  localparam logic [31:0] PM_NOP_OP = 32'h0000_0000;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } pm_state_e;
endpackage

// File: rtl/pm_ram.sv
// Single-port synchronous RAM, registered read, optional parity column.
module pm_ram #(
  parameter int unsigned W      = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8,
  parameter bit          PAR_EN = 1'b0
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  input  logic          wpar,
  output logic [W-1:0]  rdata,
  output logic          rpar
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re && !we) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

  generate
    if (PAR_EN) begin : g_par
      logic par_mem [DEPTH];
      logic rpar_q, rpar_d;

      always_comb begin
        rpar_d = rpar_q;
        if (re && !we) rpar_d = par_mem[addr];
      end

      always_ff @(posedge clk) begin
        if (we) par_mem[addr] <= wpar;
        rpar_q <= rpar_d;
      end

      assign rpar = rpar_q;
    end else begin : g_nopar
      logic unused_wpar;
      assign unused_wpar = wpar;
      assign rpar        = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/prg_mem_rspndr.sv
// PM responder: boot-loads memory from a valid/ready stream, then serves
// sequencer fetches with 1-cycle latency. PM_PARITY_EN adds a parity column.
module prg_mem_rspndr
  import pm_pkg::*;
#(
  parameter int unsigned       DATA_W = PM_DATA_W,
  parameter int unsigned       ADDR_W = PM_ADDR_W,
  parameter int unsigned       DEPTH  = PM_DEPTH,
  parameter logic [DATA_W-1:0] NOP_OP = DATA_W'(PM_NOP_OP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps_pm_cslt,
  input  logic              ps_pm_wrb,
  input  logic [ADDR_W-1:0] ps_pm_add,
  input  logic [DATA_W-1:0] ps_pm_wdt,
  output logic [DATA_W-1:0] pm_ps_op,
  output logic              pm_ps_rdy,
  output logic              pm_ps_err,
  input  logic              ld_vld,
  input  logic [DATA_W-1:0] ld_dt,
  input  logic              ld_last,
`ifdef PM_PARITY_EN
  input  logic              pm_inj_par,
`endif
  output logic              ld_rdy
);
  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic              rd_pend_q, rd_pend_d;
  logic              err_q, err_d;
  logic              boot_q;

  logic              in_range, xfer, seq_rd, seq_wr;
  logic              ram_we, ram_re, ram_wpar, ram_rpar, par_ok;
  logic [CNT_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, rd_op;

  assign in_range = 32'(ps_pm_add) < 32'(DEPTH);
  // ld_rdy stays low for one cycle after reset release
  assign ld_rdy   = (state_q == LOAD) && boot_q;
  assign xfer     = ld_rdy && ld_vld;
  assign seq_rd   = (state_q == SERVE) && ps_pm_cslt && !ps_pm_wrb;
  assign seq_wr   = (state_q == SERVE) && ps_pm_cslt && ps_pm_wrb;

  assign ram_we    = xfer || (seq_wr && in_range);
  assign ram_re    = seq_rd && in_range;
  assign ram_addr  = (state_q == LOAD) ? cnt_q : ps_pm_add[CNT_W-1:0];
  assign ram_wdata = (state_q == LOAD) ? ld_dt : ps_pm_wdt;

`ifdef PM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  assign ram_wpar = (^ram_wdata) ^ pm_inj_par;
  assign par_ok   = ((^ram_rdata) == ram_rpar);
`else
  localparam bit PAR_EN = 1'b0;
  logic unused_rpar;
  assign unused_rpar = ram_rpar;
  assign ram_wpar    = 1'b0;
  assign par_ok      = 1'b1;
`endif

  pm_ram #(
    .W(DATA_W), .DEPTH(DEPTH), .AW(CNT_W), .PAR_EN(PAR_EN)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .wpar  (ram_wpar),
    .rdata (ram_rdata),
    .rpar  (ram_rpar)
  );

  // Output is the RAM register for the cycle after a read, else the held value
  assign rd_op     = par_ok ? ram_rdata : NOP_OP;
  assign pm_ps_op  = rd_pend_q ? rd_op : op_q;
  assign pm_ps_rdy = (state_q == SERVE);
  assign pm_ps_err = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = pm_ps_op;
    rd_pend_d = 1'b0;
    err_d     = err_q;
    if (rd_pend_q && !par_ok) err_d = 1'b1;
    if (state_q == LOAD) begin
      op_d = NOP_OP;
      if (ps_pm_cslt && ps_pm_wrb) err_d = 1'b1;
      if (xfer) begin
        if (ld_last || cnt_q == CNT_W'(DEPTH - 1)) state_d = SERVE;
        else cnt_d = cnt_q + 1'b1;
      end
    end else if (ps_pm_cslt) begin
      if (!in_range) err_d = 1'b1;
      if (ps_pm_wrb || !in_range) op_d = NOP_OP;
      else rd_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      op_q      <= NOP_OP;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
      boot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_pend_q <= rd_pend_d;
      err_q     <= err_d;
      boot_q    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_prg_mem_rspndr.sv
// Directed bench: boot, gapped load, depth-limited load, write/read, range error, mid-load reset.
module tb_prg_mem_rspndr;
  logic        clk = 1'b0;
  logic        rst;
  logic        cslt, wrb, ld_vld, ld_last;
  logic [15:0] add;
  logic [31:0] wdt, ld_dt, op;
  logic        rdy, err, ld_rdy;
  logic        cslt4, wrb4, ld_vld4, ld_last4;
  logic [15:0] add4;
  logic [31:0] wdt4, ld_dt4, op4;
  logic        rdy4, err4, ld_rdy4;
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  prg_mem_rspndr u_dut (
    .clk(clk), .rst(rst), .ps_pm_cslt(cslt), .ps_pm_wrb(wrb), .ps_pm_add(add),
    .ps_pm_wdt(wdt), .pm_ps_op(op), .pm_ps_rdy(rdy), .pm_ps_err(err),
    .ld_vld(ld_vld), .ld_dt(ld_dt), .ld_last(ld_last),
`ifdef PM_PARITY_EN
    .pm_inj_par(1'b0),
`endif
    .ld_rdy(ld_rdy)
  );

  prg_mem_rspndr #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .ps_pm_cslt(cslt4), .ps_pm_wrb(wrb4), .ps_pm_add(add4),
    .ps_pm_wdt(wdt4), .pm_ps_op(op4), .pm_ps_rdy(rdy4), .pm_ps_err(err4),
    .ld_vld(ld_vld4), .ld_dt(ld_dt4), .ld_last(ld_last4),
`ifdef PM_PARITY_EN
    .pm_inj_par(1'b0),
`endif
    .ld_rdy(ld_rdy4)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    cslt = 0; wrb = 0; add = '0; wdt = '0; ld_vld = 0; ld_dt = '0; ld_last = 0;
    cslt4 = 0; wrb4 = 0; add4 = '0; wdt4 = '0; ld_vld4 = 0; ld_dt4 = '0; ld_last4 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    repeat (2) cyc();
    rst = 1;
    cyc();
  endtask

  task automatic load(input logic [31:0] d, input logic last);
    ld_vld = 1; ld_dt = d; ld_last = last;
    cyc();
    ld_vld = 0; ld_last = 0;
  endtask

  task automatic rd(input logic [15:0] a);
    cslt = 1; wrb = 0; add = a;
    cyc();
    cslt = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    cslt = 1; wrb = 1; add = a; wdt = d;
    cyc();
    cslt = 0; wrb = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    cyc();
    nvec++; if (op !== 32'h0) begin nerr++; $display("FAIL rst_op got=%h exp=%h", op, 32'h0); end
    nvec++; if (rdy !== 1'b0) begin nerr++; $display("FAIL rst_rdy got=%b exp=0", rdy); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rst_err got=%b exp=0", err); end
    rst = 1;
    #1;
    nvec++; if (ld_rdy !== 1'b0) begin nerr++; $display("FAIL rst_ldrdy_first got=%b exp=0", ld_rdy); end
    cyc();
    nvec++; if (ld_rdy !== 1'b1) begin nerr++; $display("FAIL rst_ldrdy_after got=%b exp=1", ld_rdy); end
  endtask

  task automatic test_boot();
    logic [31:0] exp [3] = '{32'hA0000001, 32'hA0000002, 32'hA0000003};
    do_reset();
    load(exp[0], 0);
    load(exp[1], 0);
    nvec++; if (ld_rdy !== 1'b1 || rdy !== 1'b0) begin nerr++; $display("FAIL boot_mid got ld_rdy=%b rdy=%b exp 1/0", ld_rdy, rdy); end
    load(exp[2], 1);
    nvec++; if (ld_rdy !== 1'b0) begin nerr++; $display("FAIL boot_ldrdy got=%b exp=0", ld_rdy); end
    nvec++; if (rdy !== 1'b1) begin nerr++; $display("FAIL boot_rdy got=%b exp=1", rdy); end
    for (int i = 0; i < 3; i++) begin
      rd(16'(i));
      nvec++; if (op !== exp[i]) begin nerr++; $display("FAIL boot_rd%0d got=%h exp=%h", i, op, exp[i]); end
    end
  endtask

  task automatic test_write();
    rd(16'd0);
    wr(16'd5, 32'h12345678);
    nvec++; if (op !== 32'h0) begin nerr++; $display("FAIL wr_nop got=%h exp=%h", op, 32'h0); end
    rd(16'd5);
    nvec++; if (op !== 32'h12345678) begin nerr++; $display("FAIL wr_rdback got=%h exp=%h", op, 32'h12345678); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL wr_err got=%b exp=0", err); end
  endtask

  task automatic test_oor();
    rd(16'h0100);
    nvec++; if (op !== 32'h0) begin nerr++; $display("FAIL oor_op got=%h exp=%h", op, 32'h0); end
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL oor_err got=%b exp=1", err); end
    repeat (2) cyc();
    nvec++; if (op !== 32'h0 || err !== 1'b1) begin nerr++; $display("FAIL oor_hold got op=%h err=%b exp 0/1", op, err); end
    rd(16'd1);
    nvec++; if (op !== 32'hA0000002 || err !== 1'b1) begin nerr++; $display("FAIL oor_after got op=%h err=%b exp a0000002/1", op, err); end
    cyc();
    nvec++; if (op !== 32'hA0000002) begin nerr++; $display("FAIL cslt0_hold got=%h exp=%h", op, 32'hA0000002); end
  endtask

  task automatic test_gaps();
    logic       vp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] dp [4] = '{32'h11, 32'hDEAD0001, 32'hDEAD0002, 32'h44};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ld_vld = vp[i]; ld_dt = dp[i]; ld_last = (i == 3);
      cyc();
      if (i == 2) begin
        nvec++; if (rdy !== 1'b0) begin nerr++; $display("FAIL gap_rdy got=%b exp=0", rdy); end
      end
    end
    ld_vld = 0; ld_last = 0;
    nvec++; if (rdy !== 1'b1) begin nerr++; $display("FAIL gap_done got=%b exp=1", rdy); end
    rd(16'd0);
    nvec++; if (op !== 32'h11) begin nerr++; $display("FAIL gap_rd0 got=%h exp=%h", op, 32'h11); end
    rd(16'd1);
    nvec++; if (op !== 32'h44) begin nerr++; $display("FAIL gap_rd1 got=%h exp=%h", op, 32'h44); end
  endtask

  task automatic test_load_write();
    do_reset();
    wr(16'd0, 32'hFFFF_FFFF);
    nvec++; if (err !== 1'b1 || op !== 32'h0) begin nerr++; $display("FAIL ldwr got err=%b op=%h exp 1/0", err, op); end
    load(32'h0000_7777, 1);
    rd(16'd0);
    nvec++; if (op !== 32'h0000_7777) begin nerr++; $display("FAIL ldwr_ignored got=%h exp=%h", op, 32'h7777); end
  endtask

  task automatic test_depth4();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ld_vld4 = 1; ld_dt4 = 32'hC0 + 32'(i); ld_last4 = 0;
      #1;
      nvec++; if (ld_rdy4 !== (i < 4)) begin nerr++; $display("FAIL d4_ldrdy%0d got=%b exp=%b", i, ld_rdy4, (i < 4)); end
      cyc();
    end
    ld_vld4 = 0;
    nvec++; if (rdy4 !== 1'b1) begin nerr++; $display("FAIL d4_rdy got=%b exp=1", rdy4); end
    for (int i = 0; i < 4; i++) begin
      cslt4 = 1; wrb4 = 0; add4 = 16'(i);
      cyc();
      cslt4 = 0;
      nvec++; if (op4 !== 32'hC0 + 32'(i)) begin nerr++; $display("FAIL d4_rd%0d got=%h exp=%h", i, op4, 32'hC0 + 32'(i)); end
    end
    cslt4 = 1; add4 = 16'd4;
    cyc();
    cslt4 = 0;
    nvec++; if (op4 !== 32'h0 || err4 !== 1'b1) begin nerr++; $display("FAIL d4_oor got op=%h err=%b exp 0/1", op4, err4); end
  endtask

  task automatic test_reset_midload();
    do_reset();
    load(32'h5555_0000, 0);
    load(32'h5555_0001, 0);
    rst = 0;
    cyc();
    rst = 1;
    cyc();
    load(32'hBEEF_0000, 1);
    rd(16'd0);
    nvec++; if (op !== 32'hBEEF_0000) begin nerr++; $display("FAIL mid_rd0 got=%h exp=%h", op, 32'hBEEF0000); end
    rd(16'd1);
    nvec++; if (op !== 32'h5555_0001) begin nerr++; $display("FAIL mid_rd1 got=%h exp=%h", op, 32'h55550001); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL mid_err got=%b exp=0", err); end
  endtask

  initial begin
    idle();
    rst = 1;
    cyc();
    test_reset();
    test_boot();
    test_write();
    test_oor();
    test_gaps();
    test_load_write();
    test_depth4();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
